// File: rtl/kbd_ascii_fifo.sv
// rtl/kbd_ascii_fifo.sv - PS/2 set-2 scan-code decoder feeding an ASCII character FIFO
// Optional: define KBD_CTRL_CODES_EN to map Ctrl+letter to control codes 01..1A.
module kbd_ascii_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_ready,
  output logic          nextdata_n,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          shift_led,
  output logic          ctrl_led,
  output logic          caps_led
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state;
  logic          caps_held;
  logic          take;
  logic          let_hit;
  logic [4:0]    let_idx;
  logic          sym_hit;
  logic [7:0]    sym_lo;
  logic [7:0]    sym_hi;
  logic          ctrl_map;
  logic          push_req;
  logic [7:0]    push_char;
  logic          push;
  logic          pop;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign take       = ps2_ready & ~clr;
  assign nextdata_n = ~take;

`ifdef KBD_CTRL_CODES_EN
  assign ctrl_map = ctrl_led;
`else
  assign ctrl_map = 1'b0;
`endif

  // Letter keys: index 0..25 for a..z
  always_comb begin
    let_hit = 1'b1;
    let_idx = 5'd0;
    case (ps2_data)
      8'h1C: let_idx = 5'd0;
      8'h32: let_idx = 5'd1;
      8'h21: let_idx = 5'd2;
      8'h23: let_idx = 5'd3;
      8'h24: let_idx = 5'd4;
      8'h2B: let_idx = 5'd5;
      8'h34: let_idx = 5'd6;
      8'h33: let_idx = 5'd7;
      8'h43: let_idx = 5'd8;
      8'h3B: let_idx = 5'd9;
      8'h42: let_idx = 5'd10;
      8'h4B: let_idx = 5'd11;
      8'h3A: let_idx = 5'd12;
      8'h31: let_idx = 5'd13;
      8'h44: let_idx = 5'd14;
      8'h4D: let_idx = 5'd15;
      8'h15: let_idx = 5'd16;
      8'h2D: let_idx = 5'd17;
      8'h1B: let_idx = 5'd18;
      8'h2C: let_idx = 5'd19;
      8'h3C: let_idx = 5'd20;
      8'h2A: let_idx = 5'd21;
      8'h1D: let_idx = 5'd22;
      8'h22: let_idx = 5'd23;
      8'h35: let_idx = 5'd24;
      8'h1A: let_idx = 5'd25;
      default: let_hit = 1'b0;
    endcase
  end

  // Digits, punctuation and fixed keys: unshifted / shifted character
  always_comb begin
    sym_hit = 1'b1;
    sym_lo  = 8'h00;
    sym_hi  = 8'h00;
    case (ps2_data)
      8'h16: {sym_lo, sym_hi} = {8'h31, 8'h21};
      8'h1E: {sym_lo, sym_hi} = {8'h32, 8'h40};
      8'h26: {sym_lo, sym_hi} = {8'h33, 8'h23};
      8'h25: {sym_lo, sym_hi} = {8'h34, 8'h24};
      8'h2E: {sym_lo, sym_hi} = {8'h35, 8'h25};
      8'h36: {sym_lo, sym_hi} = {8'h36, 8'h5E};
      8'h3D: {sym_lo, sym_hi} = {8'h37, 8'h26};
      8'h3E: {sym_lo, sym_hi} = {8'h38, 8'h2A};
      8'h46: {sym_lo, sym_hi} = {8'h39, 8'h28};
      8'h45: {sym_lo, sym_hi} = {8'h30, 8'h29};
      8'h4E: {sym_lo, sym_hi} = {8'h2D, 8'h5F};
      8'h55: {sym_lo, sym_hi} = {8'h3D, 8'h2B};
      8'h54: {sym_lo, sym_hi} = {8'h5B, 8'h7B};
      8'h5B: {sym_lo, sym_hi} = {8'h5D, 8'h7D};
      8'h5D: {sym_lo, sym_hi} = {8'h5C, 8'h7C};
      8'h4C: {sym_lo, sym_hi} = {8'h3B, 8'h3A};
      8'h52: {sym_lo, sym_hi} = {8'h27, 8'h22};
      8'h41: {sym_lo, sym_hi} = {8'h2C, 8'h3C};
      8'h49: {sym_lo, sym_hi} = {8'h2E, 8'h3E};
      8'h4A: {sym_lo, sym_hi} = {8'h2F, 8'h3F};
      8'h0E: {sym_lo, sym_hi} = {8'h60, 8'h7E};
      8'h29: {sym_lo, sym_hi} = {8'h20, 8'h20};
      8'h5A: {sym_lo, sym_hi} = {8'h0D, 8'h0D};
      8'h66: {sym_lo, sym_hi} = {8'h08, 8'h08};
      8'h0D: {sym_lo, sym_hi} = {8'h09, 8'h09};
      8'h76: {sym_lo, sym_hi} = {8'h1B, 8'h1B};
      default: sym_hit = 1'b0;
    endcase
  end

  // Translation sees the modifier state from before the consuming edge
  always_comb begin
    push_req  = 1'b0;
    push_char = 8'h00;
    if (take) begin
      case (state)
        IDLE: begin
          if (let_hit) begin
            push_req = 1'b1;
            if (ctrl_map)
              push_char = {3'b000, let_idx} + 8'd1;
            else
              push_char = ((shift_led ^ caps_led) ? 8'h41 : 8'h61) + {3'b000, let_idx};
          end else if (sym_hit) begin
            push_req  = 1'b1;
            push_char = shift_led ? sym_hi : sym_lo;
          end
        end
        EXT: begin
          if (ps2_data == 8'h4A) begin
            push_req  = 1'b1;
            push_char = 8'h2F;
          end else if (ps2_data == 8'h5A) begin
            push_req  = 1'b1;
            push_char = 8'h0D;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      shift_led <= 1'b0;
      ctrl_led  <= 1'b0;
      caps_led  <= 1'b0;
      caps_held <= 1'b0;
    end else if (take) begin
      case (state)
        IDLE: begin
          case (ps2_data)
            8'hF0: state <= BRK;
            8'hE0: state <= EXT;
            8'h12, 8'h59: shift_led <= 1'b1;
            8'h14: ctrl_led <= 1'b1;
            8'h58: begin
              if (!caps_held) caps_led <= ~caps_led;
              caps_held <= 1'b1;
            end
            default: ;
          endcase
        end
        BRK: begin
          case (ps2_data)
            8'h12, 8'h59: shift_led <= 1'b0;
            8'h14: ctrl_led <= 1'b0;
            8'h58: caps_held <= 1'b0;
            default: ;
          endcase
          state <= IDLE;
        end
        EXT: begin
          if (ps2_data == 8'h14) ctrl_led <= 1'b1;
          state <= (ps2_data == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          if (ps2_data == 8'h14) ctrl_led <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop     = rd_en & ~empty;
  assign push    = push_req & (~full | pop);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      // A drop in the same cycle as a clear keeps the flag set
      if (push_req && !push)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// tb/tb_kbd_ascii_fifo.sv - scoreboard bench for kbd_ascii_fifo against a table-driven keyboard model
module tb_kbd_ascii_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [7:0]    ps2_data = 8'h00;
  logic          ps2_ready = 1'b0;
  logic          nextdata_n;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic          shift_led;
  logic          ctrl_led;
  logic          caps_led;

  always #5 clk = ~clk;

  kbd_ascii_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clr(clr), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .nextdata_n(nextdata_n), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .ovf_clr(ovf_clr),
    .shift_led(shift_led), .ctrl_led(ctrl_led), .caps_led(caps_led)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int mon_e;

  bit m_shift, m_ctrl, m_caps, m_held, m_f0, m_e0, m_ovf;
  int m_count;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
    8'h49, 8'h4A, 8'h0E};
  logic [7:0] fix_codes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] fix_vals  [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  string lower_s   = "abcdefghijklmnopqrstuvwxyz";
  string upper_s   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  logic [7:0] sym_norm_v [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h30, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
    8'h2E, 8'h2F, 8'h60};
  logic [7:0] sym_shift_v [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
    8'h2A, 8'h28, 8'h29, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
    8'h3E, 8'h3F, 8'h7E};

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int translate(input logic [7:0] b);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) begin
`ifdef KBD_CTRL_CODES_EN
        if (m_ctrl) return i + 1;
`endif
        return (m_shift ^ m_caps) ? int'(upper_s[i]) : int'(lower_s[i]);
      end
    for (int i = 0; i < 21; i++)
      if (sym_codes[i] == b) return m_shift ? int'(sym_shift_v[i]) : int'(sym_norm_v[i]);
    for (int i = 0; i < 5; i++)
      if (fix_codes[i] == b) return int'(fix_vals[i]);
    return -1;
  endfunction

  // Advances the model by the edge that will consume these inputs
  task automatic model_step(input logic [7:0] b, input bit rdy, input bit rd, input bit oc, input bit c);
    int ch;
    bit pop, acc;
    if (c) begin
      {m_shift, m_ctrl, m_caps, m_held, m_f0, m_e0, m_ovf} = '0;
      m_count = 0;
      exp_q.delete();
      return;
    end
    ch = -1;
    if (rdy) begin
      if (m_e0 && m_f0) begin
        if (b == 8'h14) m_ctrl = 0;
        m_e0 = 0;
        m_f0 = 0;
      end else if (m_f0) begin
        if (b == 8'h12 || b == 8'h59) m_shift = 0;
        if (b == 8'h14) m_ctrl = 0;
        if (b == 8'h58) m_held = 0;
        m_f0 = 0;
      end else if (m_e0) begin
        if (b == 8'hF0) m_f0 = 1;
        else begin
          if (b == 8'h14) m_ctrl = 1;
          if (b == 8'h4A) ch = "/";
          if (b == 8'h5A) ch = 13;
          m_e0 = 0;
        end
      end else begin
        case (b)
          8'hF0: m_f0 = 1;
          8'hE0: m_e0 = 1;
          8'h12, 8'h59: m_shift = 1;
          8'h14: m_ctrl = 1;
          8'h58: begin
            if (!m_held) m_caps = !m_caps;
            m_held = 1;
          end
          default: ch = translate(b);
        endcase
      end
    end
    pop = rd && (m_count > 0);
    acc = (ch >= 0) && (m_count < DEPTH || pop);
    if (acc) exp_q.push_back(ch);
    m_count = m_count + int'(acc) - int'(pop);
    if (ch >= 0 && !acc) m_ovf = 1;
    else if (oc) m_ovf = 0;
  endtask

  task automatic check_status();
    cmp("count", int'(count), m_count);
    cmp("empty", int'(empty), int'(m_count == 0));
    cmp("full", int'(full), int'(m_count == DEPTH));
    cmp("overflow", int'(overflow), int'(m_ovf));
    cmp("shift_led", int'(shift_led), int'(m_shift));
    cmp("ctrl_led", int'(ctrl_led), int'(m_ctrl));
    cmp("caps_led", int'(caps_led), int'(m_caps));
  endtask

  task automatic drive(input logic [7:0] b, input bit rdy, input bit rd, input bit oc, input bit c);
    @(posedge clk);
    #1;
    check_status();
    ps2_data  = b;
    ps2_ready = rdy;
    rd_en     = rd;
    ovf_clr   = oc;
    clr       = c;
    model_step(b, rdy, rd, oc, c);
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic read_expect(input string name, input int v);
    cmp(name, int'(rd_data), v);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands a character out
  always @(negedge clk) begin
    cmp("nextdata_n", int'(nextdata_n), int'(!(ps2_ready && !clr)));
    if (!clr && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        cmp("rd_data_unexpected", int'(rd_data), -1);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("rd_data", int'(rd_data), mon_e);
      end
    end
  end

  int r;
  logic [7:0] rb;

  initial begin
    {m_shift, m_ctrl, m_caps, m_held, m_f0, m_e0, m_ovf} = '0;
    m_count = 0;
    do_reset();
    cmp("rst_empty", int'(empty), 1);
    cmp("rst_count", int'(count), 0);

    send(8'h1C); send(8'hF0); send(8'h1C); idle();
    cmp("t1_count", int'(count), 1);
    read_expect("t1_head", 8'h61);
    cmp("t1_empty", int'(empty), 1);

    do_reset();
    send(8'h12); send(8'h1C);
    cmp("t2_shift_on", int'(shift_led), 1);
    send(8'h16); send(8'hF0); send(8'h12); send(8'h1C); idle();
    cmp("t2_shift_off", int'(shift_led), 0);
    read_expect("t2_a", 8'h41);
    read_expect("t2_b", 8'h21);
    read_expect("t2_c", 8'h61);

    do_reset();
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); idle();
    cmp("t3_caps", int'(caps_led), 1);
    read_expect("t3_a", 8'h41);
    read_expect("t3_b", 8'h61);

    do_reset();
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h14); idle();
    cmp("t4_ctrl", int'(ctrl_led), 1);
    cmp("t4_count", int'(count), 1);
    read_expect("t4_cr", 8'h0D);
`ifdef KBD_CTRL_CODES_EN
    send(8'h21); idle();
    read_expect("t4_ctrl_c", 8'h03);
`endif

    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) send(8'h29);
    idle();
    cmp("t5_full", int'(full), 1);
    cmp("t5_count", int'(count), DEPTH);
    cmp("t5_ovf", int'(overflow), 1);
    drive(8'h29, 1'b1, 1'b1, 1'b0, 1'b0); idle();
    cmp("t5_count_pp", int'(count), DEPTH);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0); idle();
    cmp("t5_ovf_clr", int'(overflow), 0);

    do_reset();
    send(8'h12); send(8'h58); send(8'h14); send(8'hF0);
    drive(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h1C); idle();
    cmp("t6_shift", int'(shift_led), 0);
    cmp("t6_caps", int'(caps_led), 0);
    cmp("t6_ctrl", int'(ctrl_led), 0);
    read_expect("t6_a", 8'h61);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      rb = letter_codes[$urandom_range(0, 25)];
      else if (r < 60) rb = sym_codes[$urandom_range(0, 20)];
      else if (r < 68) rb = fix_codes[$urandom_range(0, 4)];
      else if (r < 78) rb = 8'hF0;
      else if (r < 83) rb = 8'hE0;
      else if (r < 93) begin
        case ($urandom_range(0, 3))
          0: rb = 8'h12;
          1: rb = 8'h59;
          2: rb = 8'h14;
          default: rb = 8'h58;
        endcase
      end else rb = 8'($urandom_range(0, 255));
      drive(rb, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 5);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kbd_ascii_fifo.md
# kbd_ascii_fifo

Keyboard decode stage sitting directly downstream of the PS/2 receiver FIFO. Pops raw scan-code bytes via the receiver's `ready`/`nextdata_n` handshake, tracks make/break/extended prefixes and Shift/Ctrl/Caps state, and translates make codes to ASCII. Results go into a character FIFO that the CPU I/O bus reads one byte at a time.

## Interface
- `DEPTH`, 16: character FIFO entries; power of two, 4..64.
- `CW`, $clog2(DEPTH)+1: width of `count`.
- `clk` in 1: system clock, same domain as the PS/2 receiver.
- `clr` in 1: reset, synchronous and active-high.
- `ps2_data` in 8: scan-code byte at the receiver head; valid while `ps2_ready`=1.
- `ps2_ready` in 1: receiver has at least one byte.
- `nextdata_n` out 1: active-low pop to the receiver.
- `rd_en` in 1: CPU pop of one character.
- `rd_data` out 8: ASCII at the FIFO head (show-ahead); valid when `empty`=0.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out CW: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a character was dropped.
- `ovf_clr` in 1: clears `overflow`.
- `shift_led`, `ctrl_led`, `caps_led` out 1: modifier state.

## Operation
- Consume: `nextdata_n` = ~(`ps2_ready` & ~`clr`). One byte is taken every cycle `ps2_ready`=1. The byte is sampled in that same cycle.
- Decoder FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - F0 → BRK.
  - E0 → EXT.
  - 12/59 → shift=1.
  - 14 → ctrl=1.
  - 58 → toggle caps only if `caps_held`=0, then set `caps_held`=1. Typematic repeats of 58 do not re-toggle.
  - Any other code → translate; push if mapped.
  - Typematic repeats push again.
- BRK:
  - 12/59 → shift=0.
  - 14 → ctrl=0.
  - 58 → `caps_held`=0.
  - Anything else is ignored.
  - Always returns to IDLE.
- EXT:
  - F0 → EXT_BRK.
  - 14 → ctrl=1.
  - 4A → push 2F.
  - 5A → push 0D.
  - Others ignored.
  - Returns to IDLE.
- EXT_BRK: 14 → ctrl=0. Always returns to IDLE.
- Translation:
  - Letters (1C=a, 32=b, … 1A=z): uppercase iff shift XOR caps.
  - Digits and punctuation: shifted form iff shift, e.g. 16 → 31/21, 1E → 32/40, 4E → 2D/5F.
  - Fixed codes: 29 → 20, 5A → 0D, 66 → 08, 0D → 09, 76 → 1B.
  - Unmapped codes push nothing.
- Character FIFO:
  - Push is accepted if `full`=0, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and `overflow` is set.
  - Pop when `rd_en` & ~`empty`. `rd_en` while empty is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- `overflow`: if set and clear coincide, set wins.

## Timing
- Reset values (`clr` synchronous; wins over all other inputs):
  - FSM = IDLE.
  - shift = ctrl = caps = `caps_held` = 0.
  - Pointers and `count` = 0.
  - `empty`=1, `full`=0, `overflow`=0.
  - `nextdata_n`=1 throughout reset.
- Latency: scan byte taken in cycle N → `empty`/`count`/`rd_data` updated after edge N+1 (one cycle).
- Modifier LEDs change after the edge that consumes the modifying byte. Translation uses the modifier state from before that edge.
- Pop in cycle N → next head presented after edge N+1.
- Simultaneous push and pop:
  - When full: both occur, `count` unchanged.
  - When empty: push only.
- Reset mid-sequence (e.g. after F0): the next byte is decoded from IDLE.

## Configuration
- `KBD_CTRL_CODES_EN`:
  - Defined: with ctrl=1, letters push 01..1A (a=01, z=1A), ignoring shift and caps. Other keys translate normally.
  - Undefined: ctrl is tracked only for `ctrl_led`; letters translate normally.

## Test plan
- Reset, then bytes 1C, F0 1C → one entry 61; `count`=1; after `rd_en` pulse, `empty`=1.
- 12, 1C, 16, F0 12, 1C → FIFO 41, 21, 61; `shift_led` 1 then 0.
- 58, 58 (repeat), F0 58, 1C, 12, 1C → `caps_led`=1; FIFO 41, 61.
- E0 5A, E0 F0 5A, E0 14 → FIFO 0D; `ctrl_led`=1. With `KBD_CTRL_CODES_EN`, a following 21 → 03.
- DEPTH+1 make codes of 29 with no reads → `full`=1, `count`=DEPTH, `overflow`=1. Push+pop while full keeps `count`=DEPTH. `ovf_clr` → `overflow`=0.
- Assert `clr` after an F0 byte, then send 1C → `nextdata_n`=1 during reset; FIFO holds 61; all LEDs 0.
